apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Shares one APB master port among N_REQ internal requesters, such as the UART_apb driver logic and test sequencers, using round-robin arbitration. It sequences each granted request through the APB SETUP and ACCESS phases and decodes PSEL[15:0] from the address slot field. It honours PREADY wait states and returns PRDATA and PSLVERR to the winning requester. It sits between requester logic and the APB bus, in the place the BFM APB master occupies in simulation.

## Interface
- N_REQ, 4: number of requesters (2..8).
- SLOT_LSB, 24: LSB of the 4-bit PADDR field that selects the PSEL bit.
- TIMEOUT, 255: maximum ACCESS cycles with PREADY low; used only when APB_ARB_TIMEOUT_EN is defined.
- PCLK in 1: the single clock; every flop is clocked on its rising edge.
- PRESETN in 1: reset, synchronous and active-low.
- REQ in N_REQ: request per requester; held high until its ACK.
- REQ_WRITE in N_REQ: 1 = write, 0 = read, per requester.
- REQ_ADDR in N_REQ*32: address; requester i occupies bits [32i+31:32i].
- REQ_WDATA in N_REQ*32: write data, packed the same way as REQ_ADDR.
- REQ_ACK out N_REQ: one-cycle completion pulse to the serviced requester.
- RSP_RDATA out 32: read data; valid while the ACK pulse is high.
- RSP_ERR out 1: PSLVERR or timeout; valid while the ACK pulse is high.
- RSP_TIMEOUT out 1: marks a timeout completion; valid with ACK, tied 0 when the feature is compiled out.
- PADDR out 32 / PWRITE out 1 / PWDATA out 32 / PENABLE out 1 / PSEL out 16: APB master outputs.
- PRDATA in 32 / PREADY in 1 / PSLVERR in 1: APB slave responses.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - The eligible set is REQ with the bit of any requester whose REQ_ACK is currently high masked off, so a held REQ is not regranted on its ACK cycle.
  - If the eligible set is non-empty, the round-robin pick searches from last_gnt+1 upward, wrapping at N_REQ.
  - The winner's address, write data and direction are latched; last_gnt takes the winner; the next state is SETUP.
- SETUP: PSEL[PADDR[SLOT_LSB+3:SLOT_LSB]] = 1 (one-hot), PENABLE = 0, PADDR/PWRITE/PWDATA come from the latch. The next state is always ACCESS.
- ACCESS: PENABLE = 1 and the APB outputs hold.
  - PREADY = 0: stay in ACCESS.
  - PREADY = 1: register PRDATA (writes return 0 on RSP_RDATA) and PSLVERR, pulse REQ_ACK[gnt] on the next cycle, and return to IDLE.
- Completion drops PSEL and PENABLE to 0. There is always at least one IDLE cycle between transfers.
- No requester is starved: after a grant to i, every other pending requester is served before i again.
- Requester inputs are sampled only in IDLE. Changes after the grant are ignored until the next grant.

## Timing
- Reset (PRESETN low at an edge):
  - State goes to IDLE; PSEL, PENABLE, PWRITE, REQ_ACK, RSP_ERR and RSP_TIMEOUT go to 0; PADDR, PWDATA and RSP_RDATA go to 0.
  - last_gnt = N_REQ-1, so requester 0 has priority first.
- Reset in mid-transfer abandons the transfer; no ACK is issued for it.
- Zero-wait transfer: REQ seen in IDLE in cycle 0, SETUP in cycle 1, ACCESS in cycle 2 with PREADY = 1, ACK in cycle 3. Each wait state adds one cycle.
- Back-to-back throughput: one transfer per 3 cycles plus wait states.
- All outputs are registered.
- REQ_ACK rises for exactly one cycle, and only for the requester that was granted.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to ACCESS and counts the ACCESS cycles with PREADY low.
  - On reaching TIMEOUT, the transfer ends: PSEL and PENABLE drop, and ACK is issued with RSP_ERR = 1, RSP_TIMEOUT = 1 and RSP_RDATA = 0.
  - If PREADY = 1 on the same cycle the count reaches TIMEOUT, it is a normal completion.
- APB_ARB_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, RSP_TIMEOUT is constant 0.

## Structure
- Package apb_arb_pkg holds:
  - the FSM state enum;
  - the constants PSEL_W = 16 and SLOT_W = 4;
  - a slot-to-one-hot PSEL decode function.
- Sub-module apb_rr_picker: combinational round-robin selector. It takes the eligible vector and last_gnt, and outputs a valid flag and the winner index.

## Test plan
- Single read: REQ[0] with REQ_ADDR0 = 32'h0300_0010, PREADY = 1, PRDATA = 32'hA5A5_0001.
  - Required: PSEL = 16'h0008 in cycles 1–2, PENABLE only in cycle 2.
  - Required: ACK[0] in cycle 3 with RSP_RDATA = 32'hA5A5_0001 and RSP_ERR = 0.
- Wait states and error: write to 32'h0000_0004 with PREADY low for 3 ACCESS cycles, then PSLVERR = 1 with PREADY.
  - Required: ACK[0] in cycle 6 with RSP_ERR = 1, and PADDR/PWDATA stable throughout.
- Round robin: REQ = 4'b1111 held continuously.
  - Required: grants in order 0,1,2,3,0, with each ACK a single-cycle pulse and no requester granted twice in a row.
- Ack masking: only REQ[2], held high through its ACK cycle and dropped afterwards.
  - Required: exactly one transfer and no regrant of requester 2 on its ACK cycle.
- Reset mid-ACCESS: PRESETN low for 1 cycle during wait states.
  - Required: every output is 0 on the next cycle and no ACK is issued.
  - Required: a subsequent REQ[1] completes normally.
- Timeout (with APB_ARB_TIMEOUT_EN, TIMEOUT = 4): PREADY stuck low.
  - Required: ACK after 4 ACCESS cycles with RSP_ERR = 1, RSP_TIMEOUT = 1 and RSP_RDATA = 0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// ----------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and helpers for the APB request arbiter.
//   - arb_state_t  : transfer sequencer states (IDLE, SETUP, ACCESS)
//   - PSEL_W       : width of the decoded PSEL bus
//   - SLOT_W       : width of the PADDR slot field that selects a PSEL bit
//   - slot_to_psel : slot number -> one-hot PSEL vector
// ----------------------------------------------------------------------------
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_t;

    localparam int PSEL_W = 16;
    localparam int SLOT_W = 4;

    function automatic logic [PSEL_W-1:0] slot_to_psel(input logic [SLOT_W-1:0] slot);
        logic [PSEL_W-1:0] onehot;
        onehot       = '0;
        onehot[slot] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// ----------------------------------------------------------------------------
// apb_rr_picker
// Combinational round-robin selector. Searches the eligible vector starting
// at the requester after last_gnt, wrapping at N_REQ.
// Ports:
//   eligible [N_REQ-1:0] : requesters that may be granted this cycle
//   last_gnt [IDX_W-1:0] : index of the most recent grant
//   valid                : at least one requester is eligible
//   winner   [IDX_W-1:0] : index of the selected requester (meaningful when valid)
// ----------------------------------------------------------------------------
module apb_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] last_gnt,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    // Scan from the farthest candidate (last_gnt itself) down to the nearest
    // (last_gnt+1); later hits overwrite earlier ones, so the requester closest
    // after last_gnt wins without needing a separate "found" flag.
    always_comb begin
        valid  = 1'b0;
        winner = last_gnt;
        for (int off = N_REQ; off >= 1; off--) begin
            int idx;
            idx = (int'(last_gnt) + off) % N_REQ;
            if (eligible[idx]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// ----------------------------------------------------------------------------
// apb_req_arbiter
// Shares one APB master port among N_REQ requesters with round-robin
// arbitration. Each grant is sequenced through SETUP and ACCESS, PSEL is
// decoded from PADDR[SLOT_LSB+3:SLOT_LSB], PREADY wait states are honoured and
// the response is returned with a one-cycle REQ_ACK pulse. All outputs are
// registered.
//
// Optional build macro:
//   APB_ARB_TIMEOUT_EN : abort an ACCESS phase after TIMEOUT cycles with
//                        PREADY low; completes with RSP_ERR = RSP_TIMEOUT = 1.
//
// Ports:
//   PCLK, PRESETN          : clock, synchronous active-low reset
//   REQ/REQ_WRITE [N_REQ]  : per-requester request and direction
//   REQ_ADDR/REQ_WDATA     : per-requester address/data, 32 bits each, packed
//   REQ_ACK [N_REQ]        : completion pulse to the serviced requester
//   RSP_RDATA/RSP_ERR/RSP_TIMEOUT : response, valid with REQ_ACK
//   PADDR/PWRITE/PWDATA/PENABLE/PSEL : APB master outputs
//   PRDATA/PREADY/PSLVERR  : APB slave responses
// ----------------------------------------------------------------------------
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int SLOT_LSB = 24,
    parameter int TIMEOUT  = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [N_REQ-1:0]      REQ_WRITE,
    input  logic [N_REQ*32-1:0]   REQ_ADDR,
    input  logic [N_REQ*32-1:0]   REQ_WDATA,
    output logic [N_REQ-1:0]      REQ_ACK,
    output logic [31:0]           RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic [31:0]           PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    output logic                  PENABLE,
    output logic [PSEL_W-1:0]     PSEL,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t         state, state_n;
    logic [IDX_W-1:0]   last_gnt, last_gnt_n;
    logic [IDX_W-1:0]   gnt, gnt_n;

    logic [N_REQ-1:0]   req_ack_n;
    logic [31:0]        rsp_rdata_n;
    logic               rsp_err_n;
    logic               rsp_timeout_n;
    logic [31:0]        paddr_n;
    logic               pwrite_n;
    logic [31:0]        pwdata_n;
    logic               penable_n;
    logic [PSEL_W-1:0]  psel_n;

    logic [N_REQ-1:0]   eligible;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_n;
`endif

    // A requester whose ACK is high right now is still holding REQ from the
    // transfer just finished; masking it stops an immediate regrant.
    assign eligible  = REQ & ~REQ_ACK;
    assign sel_addr  = REQ_ADDR[32*int'(pick_idx) +: 32];
    assign sel_wdata = REQ_WDATA[32*int'(pick_idx) +: 32];

    apb_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .eligible (eligible),
        .last_gnt (last_gnt),
        .valid    (pick_valid),
        .winner   (pick_idx)
    );

    // State and every output live in this register bank; the combinational
    // block below computes their next values, which keeps all outputs glitch-free.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state       <= IDLE;
            last_gnt    <= IDX_W'(N_REQ - 1);
            gnt         <= '0;
            REQ_ACK     <= '0;
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PENABLE     <= 1'b0;
            PSEL        <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            state       <= state_n;
            last_gnt    <= last_gnt_n;
            gnt         <= gnt_n;
            REQ_ACK     <= req_ack_n;
            RSP_RDATA   <= rsp_rdata_n;
            RSP_ERR     <= rsp_err_n;
            RSP_TIMEOUT <= rsp_timeout_n;
            PADDR       <= paddr_n;
            PWRITE      <= pwrite_n;
            PWDATA      <= pwdata_n;
            PENABLE     <= penable_n;
            PSEL        <= psel_n;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt    <= wait_cnt_n;
`endif
        end
    end

    // Next-state and next-output logic. APB address/data hold by default;
    // REQ_ACK defaults low so it can only ever be a single-cycle pulse.
    always_comb begin
        state_n       = state;
        last_gnt_n    = last_gnt;
        gnt_n         = gnt;
        req_ack_n     = '0;
        rsp_rdata_n   = RSP_RDATA;
        rsp_err_n     = RSP_ERR;
        rsp_timeout_n = RSP_TIMEOUT;
        paddr_n       = PADDR;
        pwrite_n      = PWRITE;
        pwdata_n      = PWDATA;
        penable_n     = PENABLE;
        psel_n        = PSEL;
`ifdef APB_ARB_TIMEOUT_EN
        wait_cnt_n    = wait_cnt;
`endif

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_n      = pick_idx;
                    last_gnt_n = pick_idx;
                    paddr_n    = sel_addr;
                    pwdata_n   = sel_wdata;
                    pwrite_n   = REQ_WRITE[pick_idx];
                    psel_n     = slot_to_psel(sel_addr[SLOT_LSB +: SLOT_W]);
                    penable_n  = 1'b0;
                    state_n    = SETUP;
                end
            end

            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                wait_cnt_n = '0;
`endif
            end

            ACCESS: begin
                if (PREADY) begin
                    req_ack_n[gnt] = 1'b1;
                    rsp_rdata_n    = PWRITE ? 32'h0 : PRDATA;
                    rsp_err_n      = PSLVERR;
                    rsp_timeout_n  = 1'b0;
                    psel_n         = '0;
                    penable_n      = 1'b0;
                    state_n        = IDLE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                // This cycle is the TIMEOUT-th with PREADY low: give up.
                else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    req_ack_n[gnt] = 1'b1;
                    rsp_rdata_n    = 32'h0;
                    rsp_err_n      = 1'b1;
                    rsp_timeout_n  = 1'b1;
                    psel_n         = '0;
                    penable_n      = 1'b0;
                    state_n        = IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
`endif
            end

            default: begin
                psel_n    = '0;
                penable_n = 1'b0;
                state_n   = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_req_arbiter
// Directed scoreboard bench for apb_req_arbiter. Stimulus pushes the expected
// response of every transfer into exp_q; a negedge monitor pops and compares
// whenever REQ_ACK is non-zero. Cycle-accurate APB phase checks are done
// inline by the stimulus. Define APB_ARB_TIMEOUT_EN to add the timeout case.
// ----------------------------------------------------------------------------
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam int N_REQ = 4;

    logic                PCLK;
    logic                PRESETN;
    logic [N_REQ-1:0]    REQ;
    logic [N_REQ-1:0]    REQ_WRITE;
    logic [N_REQ*32-1:0] REQ_ADDR;
    logic [N_REQ*32-1:0] REQ_WDATA;
    logic [N_REQ-1:0]    REQ_ACK;
    logic [31:0]         RSP_RDATA;
    logic                RSP_ERR;
    logic                RSP_TIMEOUT;
    logic [31:0]         PADDR;
    logic                PWRITE;
    logic [31:0]         PWDATA;
    logic                PENABLE;
    logic [PSEL_W-1:0]   PSEL;
    logic [31:0]         PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    logic                echo_mode;
    logic [31:0]         prdata_fix;

    typedef struct {
        logic [N_REQ-1:0] ack;
        logic [31:0]      rdata;
        logic             err;
        logic             tmo;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   fail_count  = 0;

    apb_req_arbiter #(
        .N_REQ    (N_REQ),
        .SLOT_LSB (24),
        .TIMEOUT  (4)
    ) dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .REQ         (REQ),
        .REQ_WRITE   (REQ_WRITE),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .REQ_ACK     (REQ_ACK),
        .RSP_RDATA   (RSP_RDATA),
        .RSP_ERR     (RSP_ERR),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PENABLE     (PENABLE),
        .PSEL        (PSEL),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    // Simple slave: either a fixed read value or the address plus a constant,
    // so each requester's read data identifies the address that was driven.
    assign PRDATA = echo_mode ? (PADDR + 32'h1111_0000) : prdata_fix;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        REQ_WRITE[idx]          = wr;
        REQ_ADDR[32*idx +: 32]  = addr;
        REQ_WDATA[32*idx +: 32] = wdata;
        REQ[idx]                = 1'b1;
    endtask

    task automatic push_exp(input logic [N_REQ-1:0] ack, input logic [31:0] rdata, input logic err, input logic tmo);
        exp_t e;
        e.ack   = ack;
        e.rdata = rdata;
        e.err   = err;
        e.tmo   = tmo;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Monitor: every cycle with an ACK must match the oldest expected response.
    always @(negedge PCLK) begin
        if (REQ_ACK !== '0) begin
            if (exp_q.size() == 0) begin
                check_count++;
                fail_count++;
                $display("[TB] FAIL unexpected_ack: got ack 0x%0h, expected no ack at %0t", REQ_ACK, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("mon_ack",     32'(REQ_ACK),     32'(e.ack));
                checkOutput("mon_rdata",   RSP_RDATA,        e.rdata);
                checkOutput("mon_err",     32'(RSP_ERR),     32'(e.err));
                checkOutput("mon_timeout", 32'(RSP_TIMEOUT), 32'(e.tmo));
            end
        end
    end

    initial begin
        PRESETN    = 1'b0;
        REQ        = '0;
        REQ_WRITE  = '0;
        REQ_ADDR   = '0;
        REQ_WDATA  = '0;
        PREADY     = 1'b1;
        PSLVERR    = 1'b0;
        echo_mode  = 1'b0;
        prdata_fix = 32'hA5A5_0001;

        // Reset state
        tick();
        tick();
        checkOutput("rst_psel",    32'(PSEL),    32'h0);
        checkOutput("rst_penable", 32'(PENABLE), 32'h0);
        checkOutput("rst_ack",     32'(REQ_ACK), 32'h0);
        checkOutput("rst_paddr",   PADDR,        32'h0);
        checkOutput("rst_rdata",   RSP_RDATA,    32'h0);
        PRESETN = 1'b1;
        tick();

        // Single zero-wait read from requester 0, slot 3
        applyStimulus(0, 1'b0, 32'h0300_0010, 32'h0);
        push_exp(4'b0001, 32'hA5A5_0001, 1'b0, 1'b0);
        tick();
        checkOutput("rd_c1_psel",    32'(PSEL),    32'h0008);
        checkOutput("rd_c1_penable", 32'(PENABLE), 32'h0);
        checkOutput("rd_c1_paddr",   PADDR,        32'h0300_0010);
        tick();
        checkOutput("rd_c2_psel",    32'(PSEL),    32'h0008);
        checkOutput("rd_c2_penable", 32'(PENABLE), 32'h1);
        tick();
        checkOutput("rd_c3_ack",     32'(REQ_ACK), 32'h1);
        checkOutput("rd_c3_psel",    32'(PSEL),    32'h0);
        checkOutput("rd_c3_penable", 32'(PENABLE), 32'h0);
        REQ = '0;
        echo_mode = 1'b1;
        tick();

        // Write with three wait states, then PSLVERR
        PREADY = 1'b0;
        applyStimulus(0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
        push_exp(4'b0001, 32'h0, 1'b1, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            checkOutput("wr_psel",   32'(PSEL),   32'h0001);
            checkOutput("wr_paddr",  PADDR,       32'h0000_0004);
            checkOutput("wr_pwdata", PWDATA,      32'hDEAD_BEEF);
            checkOutput("wr_pwrite", 32'(PWRITE), 32'h1);
            checkOutput("wr_penable", 32'(PENABLE), (c == 1) ? 32'h0 : 32'h1);
            if (c == 5) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end
        end
        tick();
        checkOutput("wr_c6_ack", 32'(REQ_ACK), 32'h1);
        REQ     = '0;
        PSLVERR = 1'b0;
        tick();

        // Reset while in ACCESS wait states: transfer abandoned
        PREADY = 1'b0;
        applyStimulus(3, 1'b1, 32'h0300_0000, 32'h1234_5678);
        tick();
        tick();
        tick();
        PRESETN = 1'b0;
        REQ     = '0;
        tick();
        checkOutput("mid_rst_psel",    32'(PSEL),        32'h0);
        checkOutput("mid_rst_penable", 32'(PENABLE),     32'h0);
        checkOutput("mid_rst_pwrite",  32'(PWRITE),      32'h0);
        checkOutput("mid_rst_paddr",   PADDR,            32'h0);
        checkOutput("mid_rst_pwdata",  PWDATA,           32'h0);
        checkOutput("mid_rst_ack",     32'(REQ_ACK),     32'h0);
        checkOutput("mid_rst_rdata",   RSP_RDATA,        32'h0);
        checkOutput("mid_rst_err",     32'(RSP_ERR),     32'h0);
        checkOutput("mid_rst_tmo",     32'(RSP_TIMEOUT), 32'h0);
        PRESETN = 1'b1;
        PREADY  = 1'b1;
        applyStimulus(1, 1'b0, 32'h0100_0008, 32'h0);
        push_exp(4'b0010, 32'h1211_0008, 1'b0, 1'b0);
        tick();
        checkOutput("post_rst_psel", 32'(PSEL), 32'h0002);
        tick();
        tick();
        checkOutput("post_rst_ack", 32'(REQ_ACK), 32'h2);
        REQ = '0;
        tick();

        // Round robin with all four requesters held: order 0,1,2,3,0
        PRESETN = 1'b0;
        tick();
        PRESETN = 1'b1;
        tick();
        applyStimulus(0, 1'b0, 32'h0400_0000, 32'h0);
        applyStimulus(1, 1'b0, 32'h0500_0004, 32'h0);
        applyStimulus(2, 1'b0, 32'h0600_0008, 32'h0);
        applyStimulus(3, 1'b0, 32'h0700_000C, 32'h0);
        push_exp(4'b0001, 32'h1511_0000, 1'b0, 1'b0);
        push_exp(4'b0010, 32'h1611_0004, 1'b0, 1'b0);
        push_exp(4'b0100, 32'h1711_0008, 1'b0, 1'b0);
        push_exp(4'b1000, 32'h1811_000C, 1'b0, 1'b0);
        push_exp(4'b0001, 32'h1511_0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            tick();
            tick();
            checkOutput("rr_ack", 32'(REQ_ACK), 32'(1 << (k % 4)));
        end
        REQ = '0;
        tick();
        tick();

        // Ack masking: REQ[2] held through its ACK, dropped afterwards
        applyStimulus(2, 1'b0, 32'h0200_0040, 32'h0);
        push_exp(4'b0100, 32'h1311_0040, 1'b0, 1'b0);
        tick();
        checkOutput("mask_psel", 32'(PSEL), 32'h0004);
        tick();
        tick();
        checkOutput("mask_ack", 32'(REQ_ACK), 32'h4);
        tick();
        REQ = '0;
        checkOutput("mask_no_regrant", 32'(PSEL), 32'h0);
        tick();
        checkOutput("mask_idle_psel", 32'(PSEL),    32'h0);
        checkOutput("mask_idle_ack",  32'(REQ_ACK), 32'h0);

`ifdef APB_ARB_TIMEOUT_EN
        // Timeout after four ACCESS cycles with PREADY low
        tick();
        PREADY = 1'b0;
        applyStimulus(0, 1'b0, 32'h0000_0000, 32'h0);
        push_exp(4'b0001, 32'h0, 1'b1, 1'b1);
        for (int c = 1; c <= 5; c++) tick();
        checkOutput("to_c5_penable", 32'(PENABLE), 32'h1);
        tick();
        checkOutput("to_c6_ack",  32'(REQ_ACK), 32'h1);
        checkOutput("to_c6_psel", 32'(PSEL),    32'h0);
        REQ    = '0;
        PREADY = 1'b1;
`endif

        tick();
        tick();
        tick();
        checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
